// File: rtl/ddr_rd_pkg.sv
// Shared constants and types for the DDR read-command server.
package ddr_rd_pkg;

  localparam int         DEF_DATA_W   = 512;
  localparam logic [2:0] APP_CMD_READ = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ddr_rd_cmd_server.sv
// Accepts one {base, length} read command at a time, issues per-word MIG read
// requests under a credit limit and returns the read words in order.
module ddr_rd_cmd_server
  import ddr_rd_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_STRIDE = 8,
  parameter int MAX_OUT     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ddr_cmd,
  input  logic [31:0]       ddr_cmd_base_adr,
  input  logic [15:0]       ddr_cmd_length,
  output logic              ddr_cmd_ready,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              ddr_rd_data_valid,
  output logic [DATA_W-1:0] ddr_rd_data,
  output logic              ddr_rd_last,
  output logic              cmd_done,
  output logic              err_unexpected
);

  localparam int               CNT_W         = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C     = CNT_W'(MAX_OUT);
  localparam logic [31:0]      ADDR_STRIDE_C = 32'(ADDR_STRIDE);

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_base;
  logic [15:0]       r_len;
  logic [15:0]       r_issued;
  logic [15:0]       r_returned;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_ready;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_cmd_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;

  logic        w_accept;
  logic        w_app_en;
  logic        w_req_fire;
  logic        w_last_req;
  logic        w_rd_take;
  logic        w_rd_stray;
  logic        w_last_word;
  logic [31:0] w_word_idx;

  assign w_accept   = valid_ddr_cmd & r_ready;
  assign w_app_en   = (r_state == ISSUE) && (r_issued < r_len) && (r_outstanding < MAX_OUT_C);
  assign w_req_fire = w_app_en & app_rdy;
  assign w_last_req = w_req_fire && (({1'b0, r_issued} + 17'd1) == {1'b0, r_len});

  // Read data is only legitimate while a command owns at least one credit.
  assign w_rd_take   = app_rd_data_valid && (r_state != IDLE) && (r_outstanding != '0);
  assign w_rd_stray  = app_rd_data_valid && !w_rd_take;
  assign w_last_word = w_rd_take && (({1'b0, r_returned} + 17'd1) == {1'b0, r_len});

  // Address arithmetic is 32-bit and silently wraps before truncation.
  assign w_word_idx = r_base + {16'd0, r_issued};

  // NOTE: every signal driven in always_comb gets a default first so no latch
  // is inferred on paths that do not assign it.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = (ddr_cmd_length == 16'd0) ? DONE : ISSUE;
      ISSUE:   if (w_last_req) w_next_state = DRAIN;
      DRAIN:   if (r_returned == r_len) w_next_state = IDLE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ready       <= 1'b1;
      r_base        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_returned    <= '0;
      r_outstanding <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_last     <= 1'b0;
      r_cmd_done    <= 1'b0;
      r_err         <= 1'b0;
      // NOTE: the wide data register is reset because its value is visible at
      // the port and must read 0 after reset, not because the logic needs it.
      r_rd_data     <= '0;
    end else begin
      r_state    <= w_next_state;
      r_ready    <= (w_next_state == IDLE);
      r_rd_valid <= w_rd_take;
      r_rd_last  <= w_last_word;
      r_cmd_done <= w_last_word | (w_accept && (ddr_cmd_length == 16'd0));

      if (w_rd_take)  r_rd_data <= app_rd_data;
      if (w_rd_stray) r_err     <= 1'b1;

      if (w_accept) begin
        r_base     <= ddr_cmd_base_adr;
        r_len      <= ddr_cmd_length;
        r_issued   <= '0;
        r_returned <= '0;
      end else begin
        if (w_req_fire) r_issued   <= r_issued + 16'd1;
        if (w_rd_take)  r_returned <= r_returned + 16'd1;
      end

      unique case ({w_req_fire, w_rd_take})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign ddr_cmd_ready     = r_ready;
  assign app_en            = w_app_en;
  assign app_cmd           = APP_CMD_READ;
  assign app_addr          = ADDR_W'(w_word_idx * ADDR_STRIDE_C);
  assign ddr_rd_data_valid = r_rd_valid;
  assign ddr_rd_data       = r_rd_data;
  assign ddr_rd_last       = r_rd_last;
  assign cmd_done          = r_cmd_done;
  assign err_unexpected    = r_err;

endmodule
